// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel synchroniser chain plus stability counter, with registered edge pulses.
// Define MULTI_DEBOUNCER_AUTOREPEAT_EN to add per-channel auto-repeat pulses while a channel is held high.
module multi_debouncer #(
   parameter int                  CHANNELS    = 4,
   parameter int                  CNT_W       = 17,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [CHANNELS-1:0] RST_STATE   = {CHANNELS{1'b0}},
   parameter int                  RPT_DELAY   = 1000000,
   parameter int                  RPT_PERIOD  = 250000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] switch_input,
   output logic [CHANNELS-1:0] state,
   output logic [CHANNELS-1:0] trans_up,
   output logic [CHANNELS-1:0] trans_dn,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] rpt
);

   if (CHANNELS < 1 || CNT_W < 1 || SYNC_STAGES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_check
      $error("multi_debouncer: illegal parameter combination");
   end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
`endif

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CNT_W-1:0]       count_q, count_d;
      logic                   state_q, state_d;
      logic                   up_q, up_d;
      logic                   dn_q, dn_d;
      logic                   sync_out;
      logic                   idle;
      logic                   finished;
      logic                   flip;

      assign sync_out = sync_q[SYNC_STAGES-1];
      assign idle     = (state_q == sync_out);
      assign finished = &count_q;
      assign flip     = !idle && finished;

      // Bit 0 is the first synchroniser stage; the counter wraps to 0 on the flip cycle.
      always_comb begin
         sync_d  = {sync_q[SYNC_STAGES-2:0], switch_input[gi]};
         count_d = idle ? '0 : count_q + 1'b1;
         state_d = flip ? ~state_q : state_q;
         up_d    = flip && !state_q;
         dn_d    = flip && state_q;
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            sync_q  <= {SYNC_STAGES{RST_STATE[gi]}};
            count_q <= '0;
            state_q <= RST_STATE[gi];
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
         end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
            state_q <= state_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
         end
      end

      assign state[gi]    = state_q;
      assign trans_up[gi] = up_q;
      assign trans_dn[gi] = dn_q;
      assign busy[gi]     = ~idle;

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
      logic [RPT_W-1:0] rcnt_q, rcnt_d;
      logic             rph_q, rph_d;
      logic             rpt_q, rpt_d;
      logic             rise;
      logic             fall;

      assign rise = flip && !state_q;
      assign fall = flip && state_q;

      // rph selects the interval being timed: 0 = initial delay, 1 = repeat period.
      always_comb begin
         rcnt_d = rcnt_q;
         rph_d  = rph_q;
         rpt_d  = 1'b0;
         if (rise) begin
            rcnt_d = '0;
            rph_d  = 1'b0;
         end else if (state_q && !fall) begin
            if (rcnt_q == (rph_q ? RPT_W'(RPT_PERIOD - 1) : RPT_W'(RPT_DELAY - 1))) begin
               rpt_d  = 1'b1;
               rcnt_d = '0;
               rph_d  = 1'b1;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end else begin
            rcnt_d = '0;
            rph_d  = 1'b0;
         end
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            rcnt_q <= '0;
            rph_q  <= 1'b0;
            rpt_q  <= 1'b0;
         end else begin
            rcnt_q <= rcnt_d;
            rph_q  <= rph_d;
            rpt_q  <= rpt_d;
         end
      end

      assign rpt[gi] = rpt_q;
`else
      assign rpt[gi] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: two instances (reset state 0000 and 1000), expected pulses
// are queued with their cycle number when stimulus is driven and consumed when that cycle is sampled.
module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
   localparam bit RPT_ON = 1'b1;
`else
   localparam bit RPT_ON = 1'b0;
`endif
   localparam int LAT = 18;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw = 4'b1111;
   logic [3:0] sw_b = 4'b0000;
   logic [3:0] st_a, up_a, dn_a, busy_a, rpt_a;
   logic [3:0] st_b, up_b, dn_b, busy_b, rpt_b;

   int   cyc = 0;
   logic rst_smp = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int       cyc;
      bit       b;
      logic [3:0] up;
      logic [3:0] dn;
      logic [3:0] rp;
   } ev_t;
   ev_t sb_q[$];

   logic [3:0] exp_st_a = 4'b0000;
   logic [3:0] exp_st_b = 4'b1000;
   logic [3:0] eu_a, ed_a, er_a, eu_b, ed_b, er_b;

   multi_debouncer #(
      .CHANNELS(4), .CNT_W(4), .SYNC_STAGES(2), .RST_STATE(4'b0000),
      .RPT_DELAY(20), .RPT_PERIOD(5)
   ) dut (
      .CLK(clk), .RST(rst), .switch_input(sw),
      .state(st_a), .trans_up(up_a), .trans_dn(dn_a), .busy(busy_a), .rpt(rpt_a)
   );

   multi_debouncer #(
      .CHANNELS(4), .CNT_W(4), .SYNC_STAGES(2), .RST_STATE(4'b1000),
      .RPT_DELAY(20), .RPT_PERIOD(5)
   ) dut_b (
      .CLK(clk), .RST(rst), .switch_input(sw_b),
      .state(st_b), .trans_up(up_b), .trans_dn(dn_b), .busy(busy_b), .rpt(rpt_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= rst;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic void push(input int c, input bit b, input logic [3:0] up,
                                input logic [3:0] dn, input logic [3:0] rp);
      ev_t e;
      e.cyc = c; e.b = b; e.up = up; e.dn = dn; e.rp = rp;
      sb_q.push_back(e);
   endfunction

   // Repeat pulses at rise+20, then every 5 cycles, strictly before the fall cycle.
   function automatic void push_rpt(input int ch, input int u, input int d);
      logic [3:0] m;
      m = 4'b0001 << ch;
      for (int t = u + 20; t < d; t += 5) begin
         push(t, 1'b0, 4'b0000, 4'b0000, RPT_ON ? m : 4'b0000);
      end
   endfunction

   always @(negedge clk) begin
      if (cyc > 0) begin
         eu_a = '0; ed_a = '0; er_a = '0;
         eu_b = '0; ed_b = '0; er_b = '0;
         for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
               if (sb_q[i].b) begin
                  eu_b |= sb_q[i].up; ed_b |= sb_q[i].dn; er_b |= sb_q[i].rp;
               end else begin
                  eu_a |= sb_q[i].up; ed_a |= sb_q[i].dn; er_a |= sb_q[i].rp;
               end
               $display("ev cyc=%0d dut=%s up=%b dn=%b rpt=%b", cyc, sb_q[i].b ? "b" : "a",
                        sb_q[i].up, sb_q[i].dn, sb_q[i].rp);
               sb_q.delete(i);
            end
         end
         if (rst_smp) begin
            exp_st_a = 4'b0000;
            exp_st_b = 4'b1000;
         end else begin
            exp_st_a = (exp_st_a | eu_a) & ~ed_a;
            exp_st_b = (exp_st_b | eu_b) & ~ed_b;
         end
         chk("state_a", st_a, exp_st_a);
         chk("up_a", up_a, eu_a);
         chk("dn_a", dn_a, ed_a);
         chk("rpt_a", rpt_a, er_a);
         chk("state_b", st_b, exp_st_b);
         chk("up_b", up_b, eu_b);
         chk("dn_b", dn_b, ed_b);
         chk("rpt_b", rpt_b, er_b);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int c;

      // Reset with all inputs high: nothing may leak out until the full latency after release.
      rst = 1'b1;
      sw  = 4'b1111;
      step(1);
      chk("busy_in_rst_a", busy_a, 4'b0000);
      chk("busy_in_rst_b", busy_b, 4'b0000);
      step(2);
      c   = cyc;
      rst = 1'b0;
      push(c + LAT, 1'b0, 4'b1111, 4'b0000, 4'b0000);
      push(c + LAT, 1'b1, 4'b0000, 4'b1000, 4'b0000);
      push(c + LAT + 20, 1'b0, 4'b0000, 4'b1111, 4'b0000);
      for (int ch = 0; ch < 4; ch++) push_rpt(ch, c + LAT, c + LAT + 20);
      step(5);
      chk("busy_all_a", busy_a, 4'b1111);
      chk("busy_b3", busy_b, 4'b1000);
      step(15);
      sw = 4'b0000;
      step(45);

      // Channel 0 clean step up, long hold (auto-repeat window), then step down.
      c     = cyc;
      sw[0] = 1'b1;
      push(c + LAT, 1'b0, 4'b0001, 4'b0000, 4'b0000);
      push(c + 58 + LAT, 1'b0, 4'b0000, 4'b0001, 4'b0000);
      push_rpt(0, c + LAT, c + 58 + LAT);
      step(20);
      chk("busy0_held", busy_a, 4'b0000);
      step(38);
      sw[0] = 1'b0;
      step(25);
      chk("busy0_down", busy_a, 4'b0000);

      // Channel 1 bounce: high 10, low 2, then high; the window restarts at the final rise.
      c     = cyc;
      sw[1] = 1'b1;
      step(5);
      chk("busy1_first", busy_a, 4'b0010);
      step(5);
      sw[1] = 1'b0;
      step(2);
      chk("busy1_gap", busy_a, 4'b0000);
      sw[1] = 1'b1;
      push(c + 12 + LAT, 1'b0, 4'b0010, 4'b0000, 4'b0000);
      push(c + 32 + LAT, 1'b0, 4'b0000, 4'b0010, 4'b0000);
      push_rpt(1, c + 12 + LAT, c + 32 + LAT);
      step(20);
      sw[1] = 1'b0;
      step(40);

      // Channel 2 glitch one cycle short of the window: no state change.
      sw[2] = 1'b1;
      step(8);
      chk("busy2_glitch", busy_a, 4'b0100);
      step(7);
      sw[2] = 1'b0;
      step(10);
      chk("busy2_settled", busy_a, 4'b0000);
      step(10);

      // Channel 3 reset mid-count; the second instance re-enters its reset state 1 and falls again.
      c     = cyc;
      sw[3] = 1'b1;
      step(12);
      chk("busy3_mid", busy_a, 4'b1000);
      rst   = 1'b1;
      sw[3] = 1'b0;
      step(2);
      chk("busy_rst_a", busy_a, 4'b0000);
      chk("busy_rst_b", busy_b, 4'b0000);
      rst = 1'b0;
      push(c + 14 + LAT, 1'b1, 4'b0000, 4'b1000, 4'b0000);
      step(30);

      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
